// File: rtl/match_timer.sv
// Pong match countdown timer: counts a preset MM:SS down to 00:00 in BCD on 1 Hz tick edges.
// Start/pause/clear control with clear > pause > start; all outputs come straight from flops.
module match_timer #(
  parameter int START_MIN = 3,
  parameter int START_SEC = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       time_up
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_EXP   = 2'd3
  } state_t;

  localparam logic [15:0] PRESET = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                    4'(START_SEC / 10), 4'(START_SEC % 10)};

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d, digits_dec;
  logic        tick_q, tick_rise;
  logic        running_q, paused_q, expired_q, time_up_q;
  logic        time_up_d;

  // One-second BCD borrow chain over {min_tens, min_ones, sec_tens, sec_ones}.
  function automatic logic [15:0] dec_bcd(input logic [15:0] d);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = d;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick_rise  = tick & ~tick_q;
  assign digits_dec = dec_bcd(digits_q);

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    time_up_d = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      digits_d = PRESET;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!pause && start) begin
            if (PRESET == 16'h0000) begin
              state_d   = S_EXP;
              time_up_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          // A tick coinciding with pause still counts; reaching 00:00 wins over pause.
          if (tick_rise) digits_d = digits_dec;
          if (tick_rise && digits_dec == 16'h0000) begin
            state_d   = S_EXP;
            time_up_d = 1'b1;
          end else if (pause) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!pause && start) state_d = S_RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      digits_q  <= PRESET;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      tick_q    <= tick;
      running_q <= (state_d == S_RUN);
      paused_q  <= (state_d == S_PAUSE);
      expired_q <= (state_d == S_EXP);
      time_up_q <= time_up_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = digits_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign expired = expired_q;
  assign time_up = time_up_q;

endmodule

// File: tb/tb_match_timer.sv
// Bench for match_timer: three presets (03:00, 01:00, 00:00) share one stimulus stream and are
// compared each cycle to a seconds-count model, plus constant-expectation vectors and sequences.
module tb_match_timer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;

  logic [3:0] mt [3];
  logic [3:0] mo [3];
  logic [3:0] st [3];
  logic [3:0] so [3];
  logic       run [3];
  logic       pau [3];
  logic       ex  [3];
  logic       tu  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  match_timer #(.START_MIN(3), .START_SEC(0)) u0 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .clear(clear),
    .min_tens(mt[0]), .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
    .running(run[0]), .paused(pau[0]), .expired(ex[0]), .time_up(tu[0]));

  match_timer #(.START_MIN(1), .START_SEC(0)) u1 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .clear(clear),
    .min_tens(mt[1]), .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
    .running(run[1]), .paused(pau[1]), .expired(ex[1]), .time_up(tu[1]));

  match_timer #(.START_MIN(0), .START_SEC(0)) u2 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .clear(clear),
    .min_tens(mt[2]), .min_ones(mo[2]), .sec_tens(st[2]), .sec_ones(so[2]),
    .running(run[2]), .paused(pau[2]), .expired(ex[2]), .time_up(tu[2]));

  // Reference model: remaining time as plain seconds, mode as a small integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int preset [3] = '{180, 60, 0};
  int m_secs [3];
  int m_mode [3];
  bit m_tu   [3];
  bit m_tick_prev;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_secs[i] = preset[i];
        m_mode[i] = M_IDLE;
        m_tu[i]   = 1'b0;
      end
      m_tick_prev = 1'b0;
    end else begin
      bit edge_seen;
      edge_seen = tick && !m_tick_prev;
      for (int i = 0; i < 3; i++) begin
        m_tu[i] = 1'b0;
        if (clear) begin
          m_secs[i] = preset[i];
          m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_IDLE) begin
          if (start && !pause) begin
            if (preset[i] == 0) begin
              m_mode[i] = M_EXP;
              m_tu[i]   = 1'b1;
            end else begin
              m_mode[i] = M_RUN;
            end
          end
        end else if (m_mode[i] == M_RUN) begin
          if (edge_seen) m_secs[i] = m_secs[i] - 1;
          if (edge_seen && m_secs[i] == 0) begin
            m_mode[i] = M_EXP;
            m_tu[i]   = 1'b1;
          end else if (pause) begin
            m_mode[i] = M_PAUSE;
          end
        end else if (m_mode[i] == M_PAUSE) begin
          if (start && !pause) m_mode[i] = M_RUN;
        end
      end
      m_tick_prev = tick;
    end
  end

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    m = s / 60;
    return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [19:0] dut_vec(input int i);
    return {mt[i], mo[i], st[i], so[i], run[i], pau[i], ex[i], tu[i]};
  endfunction

  task automatic chk(input string name, input int i, input logic [15:0] dig, input logic [3:0] fl);
    logic [19:0] act;
    act = dut_vec(i);
    checks++;
    if (act !== {dig, fl}) begin
      errors++;
      $display("FAIL %s inst%0d: got digits %h flags %b, want digits %h flags %b",
               name, i, act[19:4], act[3:0], dig, fl);
    end
  endtask

  task automatic check_model(input string name);
    logic [19:0] want;
    for (int i = 0; i < 3; i++) begin
      want = {to_bcd(m_secs[i]), m_mode[i] == M_RUN, m_mode[i] == M_PAUSE,
              m_mode[i] == M_EXP, m_tu[i]};
      checks++;
      if (dut_vec(i) !== want) begin
        errors++;
        $display("FAIL model_%s inst%0d: got %h want %h", name, i, dut_vec(i), want);
      end
    end
  endtask

  // Apply inputs just after a falling edge, let one rising edge pass, compare at the next fall.
  task automatic cyc(input logic t, input logic s, input logic p, input logic c);
    tick = t; start = s; pause = p; clear = c;
    @(negedge clock);
    check_model("cycle");
  endtask

  task automatic tick1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        t, s, p, c;
    logic [15:0] dig;
    logic [3:0]  fl;   // {running, paused, expired, time_up} of the 03:00 instance
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 4'b1000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0259, 4'b1000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0259, 4'b1000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0259, 4'b1000};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0258, 4'b0100};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0258, 4'b0100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0258, 4'b0100};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0258, 4'b1000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0257, 4'b1000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0257, 4'b1000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 4'b0000};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 4'b1000};

    // Reset values of all three presets.
    do_reset();
    chk("reset", 0, 16'h0300, 4'b0000);
    chk("reset", 1, 16'h0100, 4'b0000);
    chk("reset", 2, 16'h0000, 4'b0000);

    // Table vectors; the 00:00 instance must expire on the first start.
    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].t, tbl[k].s, tbl[k].p, tbl[k].c);
      chk($sformatf("vec%0d", k), 0, tbl[k].dig, tbl[k].fl);
      if (k == 1) chk("zero_preset_start", 2, 16'h0000, 4'b0011);
      if (k == 2) chk("zero_preset_pulse_end", 2, 16'h0000, 4'b0010);
    end

    // Eleven ticks then one held for five cycles.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick1();
    chk("first_tick", 0, 16'h0259, 4'b1000);
    for (int k = 0; k < 10; k++) tick1();
    chk("ten_ticks", 0, 16'h0249, 4'b1000);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_tick", 0, 16'h0248, 4'b1000);

    // 01:00 runs out; expiry then EXPIRED behaviour and clear.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick1();
    chk("min_borrow", 1, 16'h0059, 4'b1000);
    for (int k = 0; k < 58; k++) tick1();
    chk("one_left", 1, 16'h0001, 4'b1000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("expire", 1, 16'h0000, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("time_up_one_cycle", 1, 16'h0000, 4'b0010);
    for (int k = 0; k < 3; k++) tick1();
    chk("no_wrap", 1, 16'h0000, 4'b0010);
    chk("other_timer", 0, 16'h0157, 4'b1000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("exp_ignores_start_pause", 1, 16'h0000, 4'b0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("exp_clear", 1, 16'h0100, 4'b0000);

    // Pause together with a tick at 02:30.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) tick1();
    chk("at_0230", 0, 16'h0230, 4'b1000);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause_with_tick", 0, 16'h0229, 4'b0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick1();
    chk("paused_frozen", 0, 16'h0229, 4'b0100);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume", 0, 16'h0229, 4'b1000);
    tick1();
    chk("after_resume_tick", 0, 16'h0228, 4'b1000);

    // Asynchronous reset mid-count at 01:17 with tick held high.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 103; k++) tick1();
    chk("at_0117", 0, 16'h0117, 4'b1000);
    tick = 1'b1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 0, 16'h0300, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_model("after_reset");
    chk("reset_high_tick_idle", 0, 16'h0300, 4'b0000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("held_tick_no_dec", 0, 16'h0300, 4'b1000);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 12),
          1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 999) < 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
